ad9122_spi_master: RTL and testbench

//  Serial engine below the AD9122 register-config sequencer: takes one register

---
 rtl/ad9122_spi_master_if.sv | 30 +++
 rtl/ad9122_spi_master.sv | 228 ++++++++++++++++++++++
 tb/tb_ad9122_spi_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9122_spi_master_if.sv
// Request/response bus between the AD9122 register-config sequencer and the
// SPI serial engine.
//   write_req, read_req : one-cycle start strobes from the sequencer
//   ad_rw_addr          : [6:0] register address, [7] unused
//   w_ad_data           : byte to write
//   r_w_end             : one-cycle completion pulse from the engine
//   r_ad_data           : last byte read back from the DAC
//   r_data_valid        : pulses with r_w_end on reads only
//   busy                : engine is not idle
// modport master = sequencer side, modport slave = SPI engine side.
interface ad9122_spi_master_if;
  logic       write_req;
  logic       read_req;
  logic [7:0] ad_rw_addr;
  logic [7:0] w_ad_data;
  logic       r_w_end;
  logic [7:0] r_ad_data;
  logic       r_data_valid;
  logic       busy;

  modport master (
    output write_req, read_req, ad_rw_addr, w_ad_data,
    input  r_w_end, r_ad_data, r_data_valid, busy
  );

  modport slave (
    input  write_req, read_req, ad_rw_addr, w_ad_data,
    output r_w_end, r_ad_data, r_data_valid, busy
  );
endinterface

// File: rtl/ad9122_spi_master.sv
// AD9122 3-wire SPI engine. Runs one 16-bit transaction per request:
// instruction byte {rd, addr[6:0]} then data byte, MSB first, CPOL=0.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   bus          : request/response bus (slave modport)
//   spi_csn      : chip select, active-low
//   spi_sclk     : serial clock, idles low
//   spi_sdio_o   : SDIO output data
//   spi_sdio_oe  : SDIO output enable (1 = master drives)
//   spi_sdio_i   : SDIO input from pad
// All outputs come straight from flops. They are decoded from the next-state
// values so the pins line up exactly with the FSM timeline.
module ad9122_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  ad9122_spi_master_if.slave         bus,
  output logic                       spi_csn,
  output logic                       spi_sclk,
  output logic                       spi_sdio_o,
  output logic                       spi_sdio_oe,
  input  logic                       spi_sdio_i
);

  localparam int CMAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CMAX   = (CMAX_A > CS_HOLD) ? CMAX_A : CS_HOLD;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic            phase_q, phase_d;   // 0 = SCLK low phase, 1 = high phase
  logic [15:0]     shift_q, shift_d;
  logic            rd_q, rd_d;
  logic [7:0]      rx_q, rx_d;

  logic            csn_q, csn_d;
  logic            sclk_q, sclk_d;
  logic            sdio_o_q, sdio_o_d;
  logic            sdio_oe_q, sdio_oe_d;
  logic            r_w_end_q, r_w_end_d;
  logic            r_data_valid_q, r_data_valid_d;
  logic            busy_q, busy_d;
  logic [7:0]      r_ad_data_q, r_ad_data_d;

  logic            req_rd;
  logic            unused_addr_msb;

  assign unused_addr_msb = bus.ad_rw_addr[7];

  // Write wins when both strobes arrive together.
  assign req_rd = ~bus.write_req & bus.read_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    shift_d     = shift_q;
    rd_d        = rd_q;
    rx_d        = rx_q;
    r_ad_data_d = r_ad_data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.write_req || bus.read_req) begin
          rd_d    = req_rd;
          shift_d = {req_rd, bus.ad_rw_addr[6:0], req_rd ? 8'h00 : bus.w_ad_data};
          cnt_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Last clk of a high phase: capture the DAC's bit for the data byte.
            if (rd_q && bit_q[3]) begin
              rx_d = {rx_q[6:0], spi_sdio_i};
            end
            if (bit_q == 4'd15) begin
              // The final bit is captured on this same edge, so publish rx_d.
              if (rd_q) begin
                r_ad_data_d = rx_d;
              end
              state_d = HOLD;
            end else begin
              bit_d   = bit_q + 4'd1;
              phase_d = 1'b0;
              shift_d = {shift_q[14:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next-state values.
  always_comb begin
    csn_d          = 1'b1;
    sclk_d         = 1'b0;
    sdio_o_d       = sdio_o_q;
    sdio_oe_d      = 1'b0;
    r_w_end_d      = 1'b0;
    r_data_valid_d = 1'b0;
    busy_d         = (state_d != IDLE);

    unique case (state_d)
      SETUP: begin
        csn_d     = 1'b0;
        sdio_o_d  = shift_d[15];
        sdio_oe_d = 1'b1;
      end
      SHIFT: begin
        csn_d     = 1'b0;
        sclk_d    = phase_d;
        // shift_d only moves at the start of a low phase, so SDIO does too.
        sdio_o_d  = shift_d[15];
        sdio_oe_d = ~(rd_d & bit_d[3]);
      end
      HOLD: begin
        csn_d     = 1'b0;
        sdio_oe_d = ~rd_d;
      end
      DONE: begin
        r_w_end_d      = 1'b1;
        r_data_valid_d = rd_d;
      end
      default: begin
      end
    endcase
  end

  // An aborted read never writes r_ad_data; only reset itself clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_q          <= '0;
      phase_q        <= 1'b0;
      shift_q        <= '0;
      rd_q           <= 1'b0;
      rx_q           <= '0;
      csn_q          <= 1'b1;
      sclk_q         <= 1'b0;
      sdio_o_q       <= 1'b0;
      sdio_oe_q      <= 1'b0;
      r_w_end_q      <= 1'b0;
      r_data_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      r_ad_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      phase_q        <= phase_d;
      shift_q        <= shift_d;
      rd_q           <= rd_d;
      rx_q           <= rx_d;
      csn_q          <= csn_d;
      sclk_q         <= sclk_d;
      sdio_o_q       <= sdio_o_d;
      sdio_oe_q      <= sdio_oe_d;
      r_w_end_q      <= r_w_end_d;
      r_data_valid_q <= r_data_valid_d;
      busy_q         <= busy_d;
      r_ad_data_q    <= r_ad_data_d;
    end
  end

  assign spi_csn          = csn_q;
  assign spi_sclk         = sclk_q;
  assign spi_sdio_o       = sdio_o_q;
  assign spi_sdio_oe      = sdio_oe_q;
  assign bus.r_w_end      = r_w_end_q;
  assign bus.r_data_valid = r_data_valid_q;
  assign bus.busy         = busy_q;
  assign bus.r_ad_data    = r_ad_data_q;

endmodule

// File: tb/tb_ad9122_spi_master.sv
// Directed bench for ad9122_spi_master: one instance at default timing and one
// at CLK_DIV=1 driven by a bench-side register sequencer. A simple DAC model
// returns a byte on SCLK falling edges during the data phase of reads.
module tb_ad9122_spi_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ad9122_spi_master_if bus0();
  ad9122_spi_master_if bus1();

  logic csn0, sclk0, sdo0, oe0;
  logic csn1, sclk1, sdo1, oe1;
  logic sdio_drv;

  ad9122_spi_master u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus0),
    .spi_csn     (csn0),
    .spi_sclk    (sclk0),
    .spi_sdio_o  (sdo0),
    .spi_sdio_oe (oe0),
    .spi_sdio_i  (sdio_drv)
  );

  ad9122_spi_master #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) u_dut_fast (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus1),
    .spi_csn     (csn1),
    .spi_sclk    (sclk1),
    .spi_sdio_o  (sdo1),
    .spi_sdio_oe (oe1),
    .spi_sdio_i  (sdio_drv)
  );

  // Selected-instance view used by the transaction task.
  logic       sel;
  logic       csn_s, sclk_s, sdo_s, oe_s, busy_s, rend_s, valid_s;
  logic [7:0] rdata_s;
  always_comb begin
    csn_s   = sel ? csn1 : csn0;
    sclk_s  = sel ? sclk1 : sclk0;
    sdo_s   = sel ? sdo1 : sdo0;
    oe_s    = sel ? oe1 : oe0;
    busy_s  = sel ? bus1.busy : bus0.busy;
    rend_s  = sel ? bus1.r_w_end : bus0.r_w_end;
    valid_s = sel ? bus1.r_data_valid : bus0.r_data_valid;
    rdata_s = sel ? bus1.r_ad_data : bus0.r_ad_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic wr, input logic rd, input logic [7:0] addr, input logic [7:0] data);
    if (sel) begin
      bus1.write_req = wr; bus1.read_req = rd; bus1.ad_rw_addr = addr; bus1.w_ad_data = data;
    end else begin
      bus0.write_req = wr; bus0.read_req = rd; bus0.ad_rw_addr = addr; bus0.w_ad_data = data;
    end
  endtask

  // Results of the last run_txn call.
  logic [7:0]  resp;
  int          lat, csn_low, rises, ends, extra_ends, extra_low, valid_cnt;
  logic [15:0] word;
  logic        oe_lo_all, oe_hi_all, oe_hi_any, oe_b8low, busy_min, busy_after, valid_at_end;

  task automatic run_txn(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [7:0] data, input int poke_at, input int tail);
    int   guard;
    logic prev;
    logic done;
    guard = 0;
    while (busy_s && guard < 1000) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    set_req(wr, rd, addr, data);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, addr, data);
    lat = 1; csn_low = 0; rises = 0; word = '0; ends = 0; valid_cnt = 0;
    oe_lo_all = 1'b1; oe_hi_all = 1'b1; oe_hi_any = 1'b0; oe_b8low = 1'b1;
    busy_min = 1'b1; valid_at_end = 1'b0; prev = 1'b0; done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (!csn_s) csn_low++;
      if (!busy_s) busy_min = 1'b0;
      if (valid_s) valid_cnt++;
      if (sclk_s && !prev) begin
        rises++;
        word = {word[14:0], sdo_s};
        if (rises <= 8) oe_lo_all &= oe_s;
        else begin oe_hi_all &= oe_s; oe_hi_any |= oe_s; end
      end
      if (!sclk_s && prev) begin
        if (rises == 8) oe_b8low = oe_s;
        if (rises >= 8 && rises <= 15) sdio_drv = resp[15 - rises];
      end
      prev = sclk_s;
      if (rend_s) begin
        ends++;
        valid_at_end = valid_s;
        done = 1'b1;
      end else begin
        if (i == poke_at) set_req(1'b1, 1'b0, 8'h55, 8'h55);
        if (i == poke_at + 1) set_req(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        lat++;
      end
    end
    extra_ends = 0; extra_low = 0; busy_after = 1'b1;
    for (int i = 0; i < tail; i++) begin
      @(posedge clk); #1;
      if (i == 0) busy_after = busy_s;
      if (rend_s) extra_ends++;
      if (!csn_s) extra_low++;
    end
  endtask

  // CSN-high gap monitor for the fast instance.
  int hi_run  = 0;
  int min_gap = 1000;
  bit seen_low = 1'b0;
  always @(posedge clk) begin
    #1;
    if (csn1) hi_run++;
    else begin
      if (hi_run > 0 && seen_low && hi_run < min_gap) min_gap = hi_run;
      seen_low = 1'b1;
      hi_run   = 0;
    end
  end

  initial begin
    logic       prev5;
    int         r5;
    int         rend_seen;
    logic [7:0] sa, sd;
    logic       srd;
    int         rise_bad;

    rst = 1'b1; sel = 1'b0; sdio_drv = 1'b0; resp = 8'h00;
    bus0.write_req = 0; bus0.read_req = 0; bus0.ad_rw_addr = 0; bus0.w_ad_data = 0;
    bus1.write_req = 0; bus1.read_req = 0; bus1.ad_rw_addr = 0; bus1.w_ad_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csn", csn0, 1'b1);
    check("rst_sclk", sclk0, 1'b0);
    check("rst_sdio_o", sdo0, 1'b0);
    check("rst_oe", oe0, 1'b0);
    check("rst_rwend", bus0.r_w_end, 1'b0);
    check("rst_valid", bus0.r_data_valid, 1'b0);
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_rdata", bus0.r_ad_data, 8'h00);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: default write
    run_txn(1'b1, 1'b0, 8'h00, 8'h20, -1, 1);
    check("t1_latency", lat, 133);
    check("t1_csn_low", csn_low, 132);
    check("t1_rises", rises, 16);
    check("t1_word", word, 16'h0020);
    check("t1_oe_instr", oe_lo_all, 1'b1);
    check("t1_oe_data", oe_hi_all, 1'b1);
    check("t1_valid", valid_cnt, 0);
    check("t1_busy_during", busy_min, 1'b1);
    check("t1_busy_after", busy_after, 1'b0);

    // 2: read, DAC returns A5
    resp = 8'hA5;
    run_txn(1'b0, 1'b1, 8'h8E, 8'h00, -1, 1);
    check("t2_latency", lat, 133);
    check("t2_instr", word[15:8], 8'h8E);
    check("t2_rises", rises, 16);
    check("t2_oe_instr", oe_lo_all, 1'b1);
    check("t2_oe_b8low", oe_b8low, 1'b0);
    check("t2_oe_data", oe_hi_any, 1'b0);
    check("t2_rdata", rdata_s, 8'hA5);
    check("t2_valid_end", valid_at_end, 1'b1);
    check("t2_valid_cnt", valid_cnt, 1);

    // 3: simultaneous write and read, write wins
    resp = 8'h3C;
    run_txn(1'b1, 1'b1, 8'h1B, 8'hE4, -1, 1);
    check("t3_word", word, 16'h1BE4);
    check("t3_valid", valid_cnt, 0);
    check("t3_rdata_hold", rdata_s, 8'hA5);
    check("t3_oe_data", oe_hi_all, 1'b1);

    // 4: second write_req mid-transaction is dropped
    run_txn(1'b1, 1'b0, 8'h05, 8'h3C, 40, 160);
    check("t4_word", word, 16'h053C);
    check("t4_ends", ends, 1);
    check("t4_extra_ends", extra_ends, 0);
    check("t4_extra_csn", extra_low, 0);
    check("t4_busy_during", busy_min, 1'b1);
    check("t4_busy_after", busy_after, 1'b0);

    // 5: reset at start of bit 5 low phase
    @(negedge clk);
    set_req(1'b1, 1'b0, 8'h12, 8'h34);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'h00, 8'h00);
    prev5 = 1'b0; r5 = 0; rend_seen = 0;
    for (int i = 0; i < 500; i++) begin
      if (sclk0 && !prev5) r5++;
      if (!sclk0 && prev5 && r5 == 5) break;
      prev5 = sclk0;
      if (bus0.r_w_end) rend_seen++;
      @(posedge clk); #1;
    end
    check("t5_reached_bit5", r5, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_csn", csn0, 1'b1);
    check("t5_sclk", sclk0, 1'b0);
    check("t5_oe", oe0, 1'b0);
    check("t5_busy", bus0.busy, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus0.r_w_end) rend_seen++;
    end
    check("t5_no_rwend", rend_seen, 0);
    run_txn(1'b1, 1'b0, 8'h7F, 8'h81, -1, 1);
    check("t5_after_word", word, 16'h7F81);
    check("t5_after_latency", lat, 133);

    // 6: sequencer of 11 writes and 8 reads on the CLK_DIV=1 instance
    sel = 1'b1;
    rise_bad = 0;
    for (int i = 0; i < 19; i++) begin
      srd  = (i == 2 || i == 4 || i == 7 || i == 9 || i == 11 || i == 13 || i == 15 || i == 17);
      sa   = 8'(i * 7 + 3);
      sd   = 8'(i * 29 + 17);
      resp = 8'(i * 53 + 90);
      run_txn(~srd, srd, sa, sd, -1, 1);
      if (rises != 16) rise_bad++;
      check($sformatf("t6_lat_%0d", i), lat, 37);
      if (srd) begin
        check($sformatf("t6_instr_%0d", i), word[15:8], {1'b1, sa[6:0]});
        check($sformatf("t6_rdata_%0d", i), rdata_s, resp);
      end else begin
        check($sformatf("t6_word_%0d", i), word, {1'b0, sa[6:0], sd});
      end
    end
    check("t6_rises", rise_bad, 0);
    check("t6_min_gap_ge2", (min_gap >= 2), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
